// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: sequences the FC layer after pooling layer 2.
// Optional macro FC_STALL_EN adds a stall input freezing RUN/DRAIN.
module fc_layer_sequencer #(
  parameter int N_CH    = 12,
  parameter int N_PIX   = 16,
  parameter int N_OUT   = 10,
  parameter int MEM_LAT = 1,
  parameter int WA_W    = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef FC_STALL_EN
  input  logic            stall,
`endif
  output logic [3:0]      p2_ch,
  output logic [3:0]      p2_addr,
  output logic [WA_W-1:0] w_addr,
  output logic            mac_clr,
  output logic            mac_en,
  output logic [3:0]      out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, RUN, DRAIN, EMIT, FIN
  } state_e;

  localparam logic [3:0] CH_LAST  = 4'(N_CH - 1);
  localparam logic [3:0] PIX_LAST = 4'(N_PIX - 1);
  localparam logic [3:0] IDX_LAST = 4'(N_OUT - 1);
  localparam logic [1:0] DR_LAST  = 2'(MEM_LAT - 1);
  localparam logic [WA_W-1:0] WA_ONE = WA_W'(1);

  state_e               state_q, state_d;
  logic [3:0]           ch_q, ch_d;
  logic [3:0]           pix_q, pix_d;
  logic [3:0]           idx_q, idx_d;
  logic [WA_W-1:0]      wa_q, wa_d;
  logic [MEM_LAT-1:0]   pipe_q, pipe_d;
  logic [1:0]           dcnt_q, dcnt_d;
  logic                 stall_w;
  logic                 hold;
  logic                 issue;

`ifdef FC_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign hold  = stall_w && (state_q == RUN || state_q == DRAIN);
  assign issue = (state_q == RUN) && !hold;

  // Next-state, address counters and read-latency pipeline
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    idx_d   = idx_q;
    wa_d    = wa_q;
    pipe_d  = pipe_q;
    dcnt_d  = dcnt_q;
    if (!hold) begin
      pipe_d = MEM_LAT'({pipe_q, issue});
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          idx_d   = '0;
          ch_d    = '0;
          pix_d   = '0;
          wa_d    = '0;
        end
      end
      CLEAR: begin
        state_d = RUN;
      end
      RUN: begin
        if (!hold) begin
          if (pix_q == PIX_LAST && ch_q == CH_LAST) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end else begin
            wa_d = wa_q + WA_ONE;
            if (pix_q == PIX_LAST) begin
              pix_d = '0;
              ch_d  = ch_q + 4'd1;
            end else begin
              pix_d = pix_q + 4'd1;
            end
          end
        end
      end
      DRAIN: begin
        if (!hold) begin
          if (dcnt_q == DR_LAST) begin
            state_d = EMIT;
          end else begin
            dcnt_d = dcnt_q + 2'd1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = FIN;
          end else begin
            // last weight address + 1 is the next neuron's base
            state_d = CLEAR;
            idx_d   = idx_q + 4'd1;
            ch_d    = '0;
            pix_d   = '0;
            wa_d    = wa_q + WA_ONE;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        idx_d   = '0;
        ch_d    = '0;
        pix_d   = '0;
        wa_d    = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers, cleared by async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      pix_q   <= '0;
      idx_q   <= '0;
      wa_q    <= '0;
      pipe_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      idx_q   <= idx_d;
      wa_q    <= wa_d;
      pipe_q  <= pipe_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign p2_ch     = ch_q;
  assign p2_addr   = pix_q;
  assign w_addr    = wa_q;
  assign out_idx   = idx_q;
  assign mac_clr   = (state_q == CLEAR);
  assign mac_en    = pipe_q[MEM_LAT-1] && !hold;
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: directed bench for fc_layer_sequencer.
// Instance A uses MEM_LAT=1, instance B uses MEM_LAT=3.
module tb_fc_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, out_ready, stall;
  logic [3:0]  p2_ch, p2_addr, out_idx;
  logic [10:0] w_addr;
  logic        mac_clr, mac_en, out_valid, busy, done;

  logic        rst_b, start_b, ready_b;
  logic [3:0]  p2_ch_b, p2_addr_b, out_idx_b;
  logic [10:0] w_addr_b;
  logic        mac_clr_b, mac_en_b, valid_b, busy_b, done_b;

  fc_layer_sequencer #(.MEM_LAT(1)) dut_a (
    .clk(clk), .reset(rst), .start(start),
`ifdef FC_STALL_EN
    .stall(stall),
`endif
    .p2_ch(p2_ch), .p2_addr(p2_addr), .w_addr(w_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  fc_layer_sequencer #(.MEM_LAT(3)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b),
`ifdef FC_STALL_EN
    .stall(1'b0),
`endif
    .p2_ch(p2_ch_b), .p2_addr(p2_addr_b), .w_addr(w_addr_b),
    .mac_clr(mac_clr_b), .mac_en(mac_en_b), .out_idx(out_idx_b),
    .out_valid(valid_b), .out_ready(ready_b),
    .busy(busy_b), .done(done_b)
  );

  int errors = 0;
  int checks = 0;

  int n_en, n_clr, n_both, n_done, n_busy, n_hs, n_rise, n_bp_bad;
  int clr0_cyc, val0_cyc, clr5_cyc, hs4_cyc;
  int en_per[16];
  int hs_log[32];
  bit timeout;

  // Run one full pass on instance A, gathering statistics
  task automatic pass1(input int hold_idx, input int hold_n,
                       input int stray_at, input int stall_at);
    int held, cyc, post;
    logic prev_en, seen_done;
    logic [22:0] snap;
    n_en = 0; n_clr = 0; n_both = 0; n_done = 0; n_busy = 0;
    n_hs = 0; n_rise = 0; n_bp_bad = 0; timeout = 0;
    clr0_cyc = -1; val0_cyc = -1; clr5_cyc = -1; hs4_cyc = -1;
    for (int i = 0; i < 16; i++) en_per[i] = 0;
    held = 0; cyc = 0; post = 0; prev_en = 0; seen_done = 0;
    snap = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (post < 3) begin
      if (cyc >= 4000) begin
        timeout = 1;
        break;
      end
      if (busy) n_busy++;
      if (mac_en) begin
        n_en++;
        en_per[out_idx]++;
      end
      if (mac_en && !prev_en) n_rise++;
      prev_en = mac_en;
      if (mac_clr) begin
        n_clr++;
        if (out_idx == 4'd0 && clr0_cyc < 0) clr0_cyc = cyc;
        if (out_idx == 4'd5 && clr5_cyc < 0) clr5_cyc = cyc;
      end
      if (mac_clr && mac_en) n_both++;
      if (out_valid && out_idx == 4'd0 && val0_cyc < 0) val0_cyc = cyc;
      if (done) n_done++;
      if (seen_done) post++;
      if (done) seen_done = 1;
      start = (cyc == stray_at);
      stall = (cyc >= stall_at && cyc < stall_at + 4);
      if (out_valid && int'(out_idx) == hold_idx && held < hold_n) begin
        if (held == 0) snap = {out_idx, p2_ch, p2_addr, w_addr};
        else if ({out_idx, p2_ch, p2_addr, w_addr} !== snap) n_bp_bad++;
        held++;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (held > 0 && int'(out_idx) == hold_idx &&
            {out_idx, p2_ch, p2_addr, w_addr} !== snap) n_bp_bad++;
        if (n_hs < 32) hs_log[n_hs] = int'(out_idx);
        n_hs++;
        if (out_idx == 4'd4) hs4_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    stall = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; stall = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({p2_ch, p2_addr, w_addr, out_idx, mac_clr, mac_en,
         out_valid, busy, done} !== 28'd0) begin
      errors++;
      $display("FAIL reset_a: got %h expected 0",
               {p2_ch, p2_addr, w_addr, out_idx, mac_clr, mac_en,
                out_valid, busy, done});
    end
    checks++;
    if ({p2_ch_b, p2_addr_b, w_addr_b, out_idx_b, mac_clr_b, mac_en_b,
         valid_b, busy_b, done_b} !== 28'd0) begin
      errors++;
      $display("FAIL reset_b: outputs not all zero");
    end
    rst = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0",
               busy, done);
    end
  endtask

  task automatic test_full_pass();
    int bad;
    pass1(-1, 0, -1, 100000);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL full_timeout: pass did not finish");
    end
    checks++;
    if (n_hs !== 10) begin
      errors++;
      $display("FAIL full_hs: got %0d expected 10", n_hs);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) if (hs_log[i] != i) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_idx_seq: %0d wrong entries expected 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) if (en_per[i] != 192) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_en_per: %0d neurons off expected 0 (n0=%0d)",
               bad, en_per[0]);
    end
    checks++;
    if (n_clr !== 10) begin
      errors++;
      $display("FAIL full_clr: got %0d expected 10", n_clr);
    end
    checks++;
    if (n_both !== 0) begin
      errors++;
      $display("FAIL full_clr_en_overlap: got %0d expected 0", n_both);
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL full_done: got %0d expected 1", n_done);
    end
    checks++;
    if (n_busy !== 1951) begin
      errors++;
      $display("FAIL full_cycles: got %0d expected 1951", n_busy);
    end
    checks++;
    if (n_rise !== 10) begin
      errors++;
      $display("FAIL full_en_runs: got %0d expected 10", n_rise);
    end
    checks++;
    if (clr0_cyc !== 0 || val0_cyc !== 194) begin
      errors++;
      $display("FAIL full_latency: clr=%0d valid=%0d expected 0 194",
               clr0_cyc, val0_cyc);
    end
    checks++;
    if (out_idx !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_end_state: idx=%0d busy=%b expected 0 0",
               out_idx, busy);
    end
  endtask

  task automatic test_sweep();
    int t, bad;
    t = 0; bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(mac_clr && out_idx == 4'd3) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL sweep_wait: neuron 3 never cleared");
    end
    checks++;
    if ({p2_ch, p2_addr, w_addr} !== {4'd0, 4'd0, 11'd576}) begin
      errors++;
      $display("FAIL sweep_clear: got %0d/%0d/%0d expected 0/0/576",
               p2_ch, p2_addr, w_addr);
    end
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      if (p2_ch !== 4'(k / 16) || p2_addr !== 4'(k % 16) ||
          w_addr !== 11'(576 + k)) begin
        if (bad == 0)
          $display("FAIL sweep_step %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                   k, p2_ch, p2_addr, w_addr, k / 16, k % 16, 576 + k);
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_run: %0d bad steps expected 0", bad);
    end
    @(negedge clk);
    checks++;
    if ({p2_ch, p2_addr, w_addr, mac_en} !== {4'd11, 4'd15, 11'd767, 1'b1}) begin
      errors++;
      $display("FAIL sweep_drain: got %0d/%0d/%0d en=%b expected 11/15/767 1",
               p2_ch, p2_addr, w_addr, mac_en);
    end
    t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL sweep_done: timeout waiting for done");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    pass1(4, 5, -1, 100000);
    checks++;
    if (n_bp_bad !== 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d changes expected 0", n_bp_bad);
    end
    checks++;
    if (hs4_cyc !== 979 || clr5_cyc !== hs4_cyc + 1) begin
      errors++;
      $display("FAIL bp_restart: hs4=%0d clr5=%0d expected 979 980",
               hs4_cyc, clr5_cyc);
    end
    checks++;
    if (n_busy !== 1956 || n_hs !== 10) begin
      errors++;
      $display("FAIL bp_totals: busy=%0d hs=%0d expected 1956 10",
               n_busy, n_hs);
    end
  endtask

  task automatic test_abort();
    int t, nd;
    t = 0; nd = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(mac_clr && out_idx == 4'd2) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (38) @(negedge clk);
    checks++;
    if ({p2_ch, p2_addr, w_addr} !== {4'd2, 4'd5, 11'd421}) begin
      errors++;
      $display("FAIL abort_pos: got %0d/%0d/%0d expected 2/5/421",
               p2_ch, p2_addr, w_addr);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({p2_ch, p2_addr, w_addr, out_idx, mac_clr, mac_en,
         out_valid, busy, done} !== 28'd0) begin
      errors++;
      $display("FAIL abort_zero: got %h expected 0",
               {p2_ch, p2_addr, w_addr, out_idx, mac_clr, mac_en,
                out_valid, busy, done});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      if (done) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort_done: got %0d pulses expected 0", nd);
    end
    pass1(-1, 0, -1, 100000);
    checks++;
    if (n_hs !== 10 || hs_log[0] !== 0 || n_en !== 1920 || n_done !== 1) begin
      errors++;
      $display("FAIL abort_rerun: hs=%0d idx0=%0d en=%0d done=%0d expected 10 0 1920 1",
               n_hs, hs_log[0], n_en, n_done);
    end
  endtask

  task automatic test_stray_start();
    pass1(-1, 0, 50, 100000);
    checks++;
    if (n_en !== 1920 || n_hs !== 10 || n_busy !== 1951 || n_done !== 1) begin
      errors++;
      $display("FAIL stray_start: en=%0d hs=%0d busy=%0d done=%0d expected 1920 10 1951 1",
               n_en, n_hs, n_busy, n_done);
    end
  endtask

  task automatic test_mem_lat3();
    int cyc, first_en, last_en, first_v, cnt, clr_c;
    cyc = 0; first_en = -1; last_en = -1; first_v = -1; cnt = 0; clr_c = -1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    while (first_v < 0 && cyc < 400) begin
      if (mac_clr_b && clr_c < 0) clr_c = cyc;
      if (mac_en_b) begin
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        cnt++;
      end
      if (valid_b) first_v = cyc;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (clr_c !== 0 || first_en !== 4) begin
      errors++;
      $display("FAIL lat3_first_en: clr=%0d en=%0d expected 0 4",
               clr_c, first_en);
    end
    checks++;
    if (last_en !== 195 || first_v !== 196) begin
      errors++;
      $display("FAIL lat3_tail: last_en=%0d valid=%0d expected 195 196",
               last_en, first_v);
    end
    checks++;
    if (cnt !== 192) begin
      errors++;
      $display("FAIL lat3_count: got %0d expected 192", cnt);
    end
    #1 rst_b = 1'b1;
    #1;
    checks++;
    if ({busy_b, valid_b, out_idx_b, w_addr_b} !== 17'd0) begin
      errors++;
      $display("FAIL lat3_reset: busy=%b valid=%b idx=%0d wa=%0d expected 0",
               busy_b, valid_b, out_idx_b, w_addr_b);
    end
    @(negedge clk);
    rst_b = 1'b0;
  endtask

`ifdef FC_STALL_EN
  task automatic test_stall();
    pass1(-1, 0, -1, 20);
    checks++;
    if (en_per[0] !== 192 || n_en !== 1920) begin
      errors++;
      $display("FAIL stall_count: n0=%0d total=%0d expected 192 1920",
               en_per[0], n_en);
    end
    checks++;
    if (val0_cyc !== 198 || n_busy !== 1955) begin
      errors++;
      $display("FAIL stall_latency: valid=%0d busy=%0d expected 198 1955",
               val0_cyc, n_busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_pass();
    test_sweep();
    test_backpressure();
    test_abort();
    test_stray_start();
    test_mem_lat3();
`ifdef FC_STALL_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
